// File: rtl/maxnet_engine.sv
// Maxnet winner-take-all engine: iterates t_i <= ReLU(t_i - eps*sum_{j!=i} t_j) until one survivor.
// Optional build macro: MAXNET_TIE_DETECT_EN adds the `tie` output.

module maxnet_lane #(
  parameter int W    = 32,
  parameter int FRAC = 16,
  parameter int SW   = 34
) (
  input  logic [SW-1:0] total,
  input  logic [W-1:0]  t,
  input  logic [W-1:0]  eps,
  output logic [W-1:0]  t_next
);
  localparam int PW = SW + W;

  logic [SW-1:0] s;
  logic [PW-1:0] prod;
  logic [PW-1:0] inh;

  // All operands are non-negative, so a plain right shift truncates toward zero.
  always_comb begin
    s      = total - SW'(t);
    prod   = PW'(s) * PW'(eps);
    inh    = prod >> FRAC;
    t_next = (inh >= PW'(t)) ? '0 : t - inh[W-1:0];
  end
endmodule

module maxnet_engine #(
  parameter  int N        = 4,
  parameter  int W        = 32,
  parameter  int FRAC     = 16,
  parameter  int MAX_ITER = 64,
  localparam int IDXW     = $clog2(N),
  localparam int IW       = $clog2(MAX_ITER + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N*W-1:0]  in_data,
  input  logic [W-1:0]    eps,
  output logic            busy,
  output logic            done,
  output logic [IDXW-1:0] winner_idx,
  output logic [W-1:0]    winner_val,
  output logic [IW-1:0]   iter_count,
  output logic            timeout
`ifdef MAXNET_TIE_DETECT_EN
  ,
  output logic            tie
`endif
);
  localparam int SW = W + $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e                 state_q, state_d;
  logic [N-1:0][W-1:0]    x_q, x_d, t_q, t_d, t_nxt;
  logic [W-1:0]           eps_q, eps_d;
  logic [IW-1:0]          iter_q, iter_d;
  logic [N-1:0]           prev_mask_q, prev_mask_d, mask_now;
  logic [IDXW-1:0]        widx_q, widx_d, low_now, low_prev;
  logic [W-1:0]           wval_q, wval_d;
  logic                   timeout_q, timeout_d;
  logic [SW-1:0]          total;
  logic [CW-1:0]          surv;
`ifdef MAXNET_TIE_DETECT_EN
  logic                   tie_q, tie_d;
`endif

  for (genvar g = 0; g < N; g++) begin : g_lane
    maxnet_lane #(.W(W), .FRAC(FRAC), .SW(SW)) u_lane (
      .total  (total),
      .t      (t_q[g]),
      .eps    (eps_q),
      .t_next (t_nxt[g])
    );
  end

  // Survivor scan; descending loop leaves the lowest set index in low_*.
  always_comb begin
    total    = '0;
    surv     = '0;
    mask_now = '0;
    low_now  = '0;
    low_prev = '0;
    for (int i = N - 1; i >= 0; i--) begin
      mask_now[i] = |t_q[i];
      total       = total + SW'(t_q[i]);
      surv        = surv + CW'(mask_now[i]);
      if (mask_now[i])    low_now  = IDXW'(i);
      if (prev_mask_q[i]) low_prev = IDXW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    t_d         = t_q;
    eps_d       = eps_q;
    iter_d      = iter_q;
    prev_mask_d = prev_mask_q;
    widx_d      = widx_q;
    wval_d      = wval_q;
    timeout_d   = timeout_q;
`ifdef MAXNET_TIE_DETECT_EN
    tie_d       = tie_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < N; i++) begin
            x_d[i] = in_data[i*W +: W];
            t_d[i] = in_data[i*W + W - 1] ? '0 : in_data[i*W +: W];
          end
          eps_d       = eps;
          iter_d      = '0;
          prev_mask_d = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (surv <= CW'(1) || iter_q == IW'(MAX_ITER)) begin
          state_d = S_FIN;
          // Annihilation falls back to the last non-empty survivor set.
          if (surv == '0 && iter_q != '0) widx_d = low_prev;
          else                            widx_d = low_now;
          wval_d    = x_q[widx_d];
          timeout_d = (surv > CW'(1));
`ifdef MAXNET_TIE_DETECT_EN
          tie_d     = (surv > CW'(1)) || (surv == '0 && iter_q != '0);
`endif
        end else begin
          t_d         = t_nxt;
          prev_mask_d = mask_now;
          iter_d      = iter_q + IW'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      t_q         <= '0;
      eps_q       <= '0;
      iter_q      <= '0;
      prev_mask_q <= '0;
      widx_q      <= '0;
      wval_q      <= '0;
      timeout_q   <= 1'b0;
`ifdef MAXNET_TIE_DETECT_EN
      tie_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      t_q         <= t_d;
      eps_q       <= eps_d;
      iter_q      <= iter_d;
      prev_mask_q <= prev_mask_d;
      widx_q      <= widx_d;
      wval_q      <= wval_d;
      timeout_q   <= timeout_d;
`ifdef MAXNET_TIE_DETECT_EN
      tie_q       <= tie_d;
`endif
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_FIN);
  assign winner_idx = widx_q;
  assign winner_val = wval_q;
  assign iter_count = iter_q;
  assign timeout    = timeout_q;
`ifdef MAXNET_TIE_DETECT_EN
  assign tie        = tie_q;
`endif
endmodule

// File: tb/tb_maxnet_engine.sv
// Scoreboard bench for maxnet_engine (N=4, W=32, FRAC=16, MAX_ITER=64).
module tb_maxnet_engine;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] in_data = '0;
  logic [31:0]  eps = '0;
  logic         busy, done, timeout;
  logic [1:0]   winner_idx;
  logic [31:0]  winner_val;
  logic [6:0]   iter_count;
`ifdef MAXNET_TIE_DETECT_EN
  logic         tie;
`endif

  int asserts = 0;
  int fails   = 0;

  typedef struct packed {
    logic        busy;
    logic [1:0]  idx;
    logic [31:0] val;
    logic [6:0]  iter;
    logic        tmo;
    logic        tie;
  } res_t;

  typedef struct {
    res_t r;
    int   lat;
  } exp_t;

  exp_t sb[$];

  maxnet_engine #(.N(4), .W(32), .FRAC(16), .MAX_ITER(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .eps        (eps),
    .busy       (busy),
    .done       (done),
    .winner_idx (winner_idx),
    .winner_val (winner_val),
    .iter_count (iter_count),
    .timeout    (timeout)
`ifdef MAXNET_TIE_DETECT_EN
    ,
    .tie        (tie)
`endif
  );

  always #5 clk = ~clk;

  function automatic res_t mk(input logic [1:0] idx, input logic [31:0] val,
                              input logic [6:0] it, input logic tmo, input logic tie_exp);
    res_t r;
    r.busy = 1'b0;
    r.idx  = idx;
    r.val  = val;
    r.iter = it;
    r.tmo  = tmo;
`ifdef MAXNET_TIE_DETECT_EN
    r.tie  = tie_exp;
`else
    r.tie  = 1'b0 & tie_exp;
`endif
    return r;
  endfunction

  function automatic res_t sample();
    res_t r;
    r.busy = busy;
    r.idx  = winner_idx;
    r.val  = winner_val;
    r.iter = iter_count;
    r.tmo  = timeout;
`ifdef MAXNET_TIE_DETECT_EN
    r.tie  = tie;
`else
    r.tie  = 1'b0;
`endif
    return r;
  endfunction

  // Pushes the expectation, then pulses start for one rising edge.
  task automatic launch(input logic [31:0] x0, x1, x2, x3, input logic [31:0] e,
                        input res_t r, input int lat);
    exp_t ex;
    ex.r = r;
    ex.lat = lat;
    sb.push_back(ex);
    @(negedge clk);
    in_data = {x3, x2, x1, x0};
    eps     = e;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Counts cycles after the start edge until done is seen (bounded).
  task automatic wait_done(output int cyc, output res_t got);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    got = sample();
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    asserts++;
    if ({done, sample()} !== '0) begin
      fails++;
      $display("FAIL reset_state got done=%b res=%h exp all zero", done, sample());
    end
  endtask

  task automatic test_dominant;
    int cyc; res_t got; exp_t e;
    launch(32'h10000, 32'h20000, 32'h30000, 32'h40000, 32'h4000, mk(2'd3, 32'h40000, 7'd4, 1'b0, 1'b0), 5);
    wait_done(cyc, got);
    e = sb.pop_front();
    asserts++;
    if (cyc != e.lat) begin fails++; $display("FAIL dominant_latency got %0d exp %0d", cyc, e.lat); end
    asserts++;
    if (got !== e.r) begin fails++; $display("FAIL dominant_result got %h exp %h", got, e.r); end
  endtask

  task automatic test_single;
    int cyc; res_t got; exp_t e;
    launch(32'h0, 32'h0, 32'h50000, 32'h0, 32'h4000, mk(2'd2, 32'h50000, 7'd0, 1'b0, 1'b0), 1);
    wait_done(cyc, got);
    e = sb.pop_front();
    asserts++;
    if (cyc != e.lat) begin fails++; $display("FAIL single_latency got %0d exp %0d", cyc, e.lat); end
    asserts++;
    if (got !== e.r) begin fails++; $display("FAIL single_result got %h exp %h", got, e.r); end
  endtask

  task automatic test_annihilation;
    int cyc; res_t got; exp_t e;
    launch(32'h10000, 32'h10000, 32'h0, 32'h0, 32'h10000, mk(2'd0, 32'h10000, 7'd1, 1'b0, 1'b1), 2);
    wait_done(cyc, got);
    e = sb.pop_front();
    asserts++;
    if (cyc != e.lat) begin fails++; $display("FAIL annih_latency got %0d exp %0d", cyc, e.lat); end
    asserts++;
    if (got !== e.r) begin fails++; $display("FAIL annih_result got %h exp %h", got, e.r); end
  endtask

  task automatic test_timeout;
    int cyc; res_t got; exp_t e;
    launch(32'h30000, 32'h30000, 32'h10000, 32'h0, 32'h4000, mk(2'd0, 32'h30000, 7'd64, 1'b1, 1'b1), 65);
    wait_done(cyc, got);
    e = sb.pop_front();
    asserts++;
    if (cyc != e.lat) begin fails++; $display("FAIL timeout_latency got %0d exp %0d", cyc, e.lat); end
    asserts++;
    if (got !== e.r) begin fails++; $display("FAIL timeout_result got %h exp %h", got, e.r); end
  endtask

  task automatic test_negative;
    int cyc; res_t got; exp_t e;
    launch(32'hFFFF0000, 32'h0, 32'h0, 32'h0, 32'h4000, mk(2'd0, 32'hFFFF0000, 7'd0, 1'b0, 1'b0), 1);
    wait_done(cyc, got);
    e = sb.pop_front();
    asserts++;
    if (cyc != e.lat) begin fails++; $display("FAIL negative_latency got %0d exp %0d", cyc, e.lat); end
    asserts++;
    if (got !== e.r) begin fails++; $display("FAIL negative_result got %h exp %h", got, e.r); end
  endtask

  // Start held through the FIN edge must not launch another run.
  task automatic test_start_in_fin;
    int cyc; res_t got; exp_t e; int activity;
    launch(32'h0, 32'h0, 32'h50000, 32'h0, 32'h4000, mk(2'd2, 32'h50000, 7'd0, 1'b0, 1'b0), 1);
    wait_done(cyc, got);
    e = sb.pop_front();
    asserts++;
    if (got !== e.r || cyc != e.lat) begin
      fails++; $display("FAIL fin_first_run got %h/%0d exp %h/%0d", got, cyc, e.r, e.lat);
    end
    in_data = {32'h40000, 32'h30000, 32'h20000, 32'h10000};
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    activity = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) activity++;
      @(negedge clk);
    end
    asserts++;
    if (activity != 0) begin fails++; $display("FAIL fin_start_ignored got %0d active cycles exp 0", activity); end
    asserts++;
    if (sample() !== e.r) begin fails++; $display("FAIL fin_results_held got %h exp %h", sample(), e.r); end
  endtask

  task automatic test_reset_abort;
    int cyc; res_t got; exp_t e; int seen;
    @(negedge clk);
    in_data = {32'h40000, 32'h30000, 32'h20000, 32'h10000};
    eps     = 32'h4000;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    asserts++;
    if (busy !== 1'b1 || iter_count !== 7'd1) begin
      fails++; $display("FAIL abort_second_start got busy=%b iter=%0d exp busy=1 iter=1", busy, iter_count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    asserts++;
    if ({done, sample()} !== '0) begin
      fails++; $display("FAIL abort_outputs got done=%b res=%h exp all zero", done, sample());
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    asserts++;
    if (seen != 0) begin fails++; $display("FAIL abort_no_done got %0d active cycles exp 0", seen); end
    launch(32'h10000, 32'h20000, 32'h30000, 32'h40000, 32'h4000, mk(2'd3, 32'h40000, 7'd4, 1'b0, 1'b0), 5);
    wait_done(cyc, got);
    e = sb.pop_front();
    asserts++;
    if (cyc != e.lat) begin fails++; $display("FAIL rerun_latency got %0d exp %0d", cyc, e.lat); end
    asserts++;
    if (got !== e.r) begin fails++; $display("FAIL rerun_result got %h exp %h", got, e.r); end
  endtask

  initial begin
    test_reset();
    test_dominant();
    test_single();
    test_annihilation();
    test_timeout();
    test_negative();
    test_start_in_fin();
    test_reset_abort();
    asserts++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_drain got %0d left exp 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
